// File: rtl/bcm_pwm_engine.sv
// Binary-code-modulation PWM engine: a weighted frame counter addresses an external
// double-buffered bit-plane memory and the returned plane word is registered onto the outputs.
module bcm_pwm_engine #(
    parameter int pwm_width      = 16,
    parameter int num_pwm        = 4,
    parameter int prescale_width = 8,
    parameter bit out_active_low = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [prescale_width-1:0]    prescale_div,
    input  logic                         swap_req,
    output logic                         swap_ack,
    output logic                         buf_sel,
    output logic [$clog2(pwm_width)-1:0] pwm_addr,
    input  logic [num_pwm-1:0]           pwm_data,
    output logic                         latch_mem,
    output logic                         frame_start,
    output logic [num_pwm-1:0]           pwm_out
);

    localparam int AW = $clog2(pwm_width);
    localparam logic [pwm_width-1:0]      CNT_ONE  = 1;
    localparam logic [pwm_width-1:0]      CNT_FULL = '1;
    localparam logic [prescale_width-1:0] PRE_ONE  = 1;
    localparam logic [num_pwm-1:0]        INACTIVE = {num_pwm{out_active_low}};

    logic [pwm_width-1:0]      counter_q, counter_d;
    logic [prescale_width-1:0] prescaler_q, prescaler_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic                      buf_sel_q, buf_sel_d;
    logic                      swap_ack_q, swap_ack_d;
    logic                      latch_q, latch_d;
    logic                      frame_start_q, frame_start_d;
    logic [num_pwm-1:0]        pwm_out_q, pwm_out_d;
    logic [num_pwm-1:0]        pol_data;
    logic                      tick;
    logic                      wrap;

    // Plane index is the position of the counter's highest set bit, so plane k spans 2^k ticks.
    function automatic logic [AW-1:0] msb_index(input logic [pwm_width-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = 0; i < pwm_width; i++) begin
            if (v[i]) idx = AW'(i);
        end
        return idx;
    endfunction

    for (genvar gi = 0; gi < num_pwm; gi++) begin : g_pol
        assign pol_data[gi] = pwm_data[gi] ^ out_active_low;
    end

    always_comb begin
        tick          = enable && (prescaler_q == prescale_div);
        wrap          = (counter_q == CNT_FULL);
        counter_d     = counter_q;
        prescaler_d   = prescaler_q;
        buf_sel_d     = buf_sel_q;
        swap_ack_d    = 1'b0;
        latch_d       = 1'b0;
        frame_start_d = 1'b0;
        pwm_out_d     = pol_data;
        if (!enable) begin
            // Stopped: restart at plane 0 on re-enable; a pending swap stays pending.
            counter_d   = CNT_ONE;
            prescaler_d = '0;
            pwm_out_d   = INACTIVE;
        end else if (tick) begin
            prescaler_d = '0;
            if (wrap) begin
                counter_d     = CNT_ONE;
                frame_start_d = 1'b1;
                latch_d       = 1'b1;
                if (swap_req) begin
                    buf_sel_d  = ~buf_sel_q;
                    swap_ack_d = 1'b1;
                end
            end else begin
                counter_d = counter_q + CNT_ONE;
            end
        end else begin
            prescaler_d = prescaler_q + PRE_ONE;
        end
        addr_d = msb_index(counter_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q     <= CNT_ONE;
            prescaler_q   <= '0;
            addr_q        <= '0;
            buf_sel_q     <= 1'b0;
            swap_ack_q    <= 1'b0;
            latch_q       <= 1'b0;
            frame_start_q <= 1'b0;
            pwm_out_q     <= INACTIVE;
        end else begin
            counter_q     <= counter_d;
            prescaler_q   <= prescaler_d;
            addr_q        <= addr_d;
            buf_sel_q     <= buf_sel_d;
            swap_ack_q    <= swap_ack_d;
            latch_q       <= latch_d;
            frame_start_q <= frame_start_d;
            pwm_out_q     <= pwm_out_d;
        end
    end

    assign swap_ack    = swap_ack_q;
    assign buf_sel     = buf_sel_q;
    assign pwm_addr    = addr_q;
    assign latch_mem   = latch_q;
    assign frame_start = frame_start_q;
    assign pwm_out     = pwm_out_q;

endmodule

// File: tb/tb_bcm_pwm_engine.sv
// Scoreboard bench for bcm_pwm_engine: a frame-position model predicts every output cycle
// for an active-high and an active-low instance sharing the same stimulus.
module tb_bcm_pwm_engine;

    localparam int PW    = 4;
    localparam int NP    = 4;
    localparam int PSW   = 8;
    localparam int AW    = $clog2(PW);
    localparam int FRAME = (1 << PW) - 1;

    logic           clk = 1'b0;
    logic           rst, enable, swap_req;
    logic [PSW-1:0] prescale_div;

    logic          a_swap_ack, a_buf_sel, a_latch_mem, a_frame_start;
    logic [AW-1:0] a_pwm_addr;
    logic [NP-1:0] a_pwm_data, a_pwm_out;
    logic          b_swap_ack, b_buf_sel, b_latch_mem, b_frame_start;
    logic [AW-1:0] b_pwm_addr;
    logic [NP-1:0] b_pwm_data, b_pwm_out;

    logic [NP-1:0] mem [2][PW];

    typedef struct packed {
        logic          ack;
        logic          bsel;
        logic [AW-1:0] addr;
        logic          latch;
        logic          fs;
        logic [NP-1:0] out_a;
        logic [NP-1:0] out_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cycle  = 0;
    bit   model_on = 1'b0;

    // Reference model: position within the frame in ticks, plus a two-deep address history.
    int m_pos = 0, m_wait = 0;
    bit m_buf = 1'b0;
    bit buf1 = 1'b0, buf2 = 1'b0;
    int pl1 = 0, pl2 = 0;

    always #5 clk = ~clk;

    bcm_pwm_engine #(.pwm_width(PW), .num_pwm(NP), .prescale_width(PSW), .out_active_low(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable), .prescale_div(prescale_div), .swap_req(swap_req),
        .swap_ack(a_swap_ack), .buf_sel(a_buf_sel), .pwm_addr(a_pwm_addr), .pwm_data(a_pwm_data),
        .latch_mem(a_latch_mem), .frame_start(a_frame_start), .pwm_out(a_pwm_out)
    );

    bcm_pwm_engine #(.pwm_width(PW), .num_pwm(NP), .prescale_width(PSW), .out_active_low(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable), .prescale_div(prescale_div), .swap_req(swap_req),
        .swap_ack(b_swap_ack), .buf_sel(b_buf_sel), .pwm_addr(b_pwm_addr), .pwm_data(b_pwm_data),
        .latch_mem(b_latch_mem), .frame_start(b_frame_start), .pwm_out(b_pwm_out)
    );

    // Bit-plane memories with one cycle read latency, one per instance.
    always @(posedge clk) begin
        a_pwm_data <= mem[a_buf_sel][a_pwm_addr];
        b_pwm_data <= mem[b_buf_sel][b_pwm_addr];
    end

    function automatic int plane_of(input int pos);
        int p;
        p = 0;
        for (int k = 0; k < PW; k++) begin
            if (pos >= (1 << k) - 1) p = k;
        end
        return p;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        logic [NP-1:0] d;
        cycle++;
        if (model_on) begin
            d = mem[buf2][pl2];
            e = '0;
            if (rst) begin
                m_pos = 0; m_wait = 0; m_buf = 1'b0;
                e.out_a = '0; e.out_b = '1;
            end else if (!enable) begin
                m_pos = 0; m_wait = 0;
                e.out_a = '0; e.out_b = '1;
            end else begin
                e.out_a = d; e.out_b = ~d;
                if (m_wait == int'(prescale_div)) begin
                    m_wait = 0;
                    if (m_pos == FRAME - 1) begin
                        m_pos = 0;
                        e.fs = 1'b1; e.latch = 1'b1;
                        if (swap_req) begin
                            m_buf = ~m_buf;
                            e.ack = 1'b1;
                        end
                    end else begin
                        m_pos++;
                    end
                end else begin
                    m_wait++;
                end
            end
            e.bsel = m_buf;
            e.addr = AW'(plane_of(m_pos));
            buf2 = buf1; pl2 = pl1;
            buf1 = m_buf; pl1 = plane_of(m_pos);
            exp_q.push_back(e);
        end
    end

    // Monitor: pops one expectation per presented output cycle and compares both instances.
    always @(posedge clk) begin
        exp_t e;
        logic [9:0] act, req;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {a_swap_ack, a_buf_sel, a_pwm_addr, a_latch_mem, a_frame_start, a_pwm_out};
            req = {e.ack, e.bsel, e.addr, e.latch, e.fs, e.out_a};
            n_cmp++;
            if (act !== req) begin
                n_fail++;
                $display("FAIL outputs_active_high cycle %0d: got %h required %h", cycle, act, req);
            end
            act = {b_swap_ack, b_buf_sel, b_pwm_addr, b_latch_mem, b_frame_start, b_pwm_out};
            req = {e.ack, e.bsel, e.addr, e.latch, e.fs, e.out_b};
            n_cmp++;
            if (act !== req) begin
                n_fail++;
                $display("FAIL outputs_active_low cycle %0d: got %h required %h", cycle, act, req);
            end
            if (e.fs)
                $display("cycle %0d frame boundary: buf_sel=%0d swap_ack=%0d", cycle, e.bsel, e.ack);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(input int pos, input bool_tick);
        for (int i = 0; i < 500; i++) begin
            if (m_pos == pos && (!bool_tick || m_wait == int'(prescale_div))) break;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; swap_req = 1'b0; prescale_div = '0;
        for (int k = 0; k < PW; k++) begin
            mem[0][k] = NP'(1 << k);
            mem[1][k] = NP'($urandom_range(0, (1 << NP) - 1));
        end
        mem[1][1][0] = 1'b1; mem[1][3][0] = 1'b1;
        mem[1][0][0] = 1'b0; mem[1][2][0] = 1'b0;
        model_on = 1'b1;
        cyc(3);
        rst = 1'b0; enable = 1'b1;
        cyc(2 * FRAME);
        // Swap requested mid-frame at counter 5 and held across one boundary.
        wait_pos(4, 1'b0);
        swap_req = 1'b1;
        cyc(FRAME);
        swap_req = 1'b0;
        cyc(FRAME);
        // Request rising exactly in the boundary cycle.
        wait_pos(FRAME - 1, 1'b1);
        swap_req = 1'b1;
        cyc(1);
        swap_req = 1'b0;
        cyc(2 * FRAME);
        // Prescaled run.
        enable = 1'b0;
        cyc(2);
        prescale_div = 8'd2;
        enable = 1'b1;
        cyc(6 * FRAME);
        // Disable at counter 9 with a swap pending, then re-enable.
        wait_pos(8, 1'b0);
        swap_req = 1'b1;
        enable = 1'b0;
        cyc(5);
        enable = 1'b1;
        cyc(3 * FRAME + 10);
        swap_req = 1'b0;
        cyc(20);
        // Reset mid-frame after a swap.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(3 * FRAME);
        // Randomised segments.
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 3))
                0: begin
                    for (int i = 0; i < int'($urandom_range(10, 60)); i++) begin
                        if ($urandom_range(0, 15) == 0) swap_req = ~swap_req;
                        cyc(1);
                    end
                end
                1: begin
                    enable = 1'b0;
                    cyc($urandom_range(1, 4));
                    prescale_div = PSW'($urandom_range(0, 3));
                    cyc(1);
                    enable = 1'b1;
                    cyc($urandom_range(5, 40));
                end
                2: begin
                    rst = 1'b1;
                    cyc($urandom_range(1, 2));
                    rst = 1'b0;
                    cyc($urandom_range(5, 40));
                end
                default: begin
                    swap_req = 1'b1;
                    cyc($urandom_range(1, 3));
                    swap_req = 1'b0;
                    cyc($urandom_range(5, 40));
                end
            endcase
        end
        cyc(4);
        if (exp_q.size() > 2) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required at most 2", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
